// File: rtl/lix_pipe_pkg.sv
// Shared definitions for the lix_pipe_arb block: round-robin pick helper,
// tag width helper and perf counter width.
package lix_pipe_pkg;

    // Widest requester vector the pick helper handles (NREQ must stay below it)
    localparam int RR_MAX   = 64;
    // Width of every performance counter
    localparam int PERF_W   = 32;
    // Default requester count
    localparam int NREQ_DEF = 3;

    // Tag width needed to name one of n requesters
    function automatic int tag_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Round-robin pick: first set bit of req at or after ptr, wrapping at n.
    // Returns a one-hot vector, or zero when no request is set.
    function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                  input int unsigned       ptr,
                                                  input int unsigned       n);
        logic [RR_MAX-1:0] g;
        logic              found;
        int unsigned       idx;
        g     = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            if (k < n && !found) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (req[idx]) begin
                    g[idx] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/lix_tag_pipe.sv
// LAT-deep {tv, tag} shift register mirroring the shared data pipeline.
// Advances only with en_i; async clear on rst_i, sync clear on flush_i.
module lix_tag_pipe #(
    parameter int LAT  = 2,
    parameter int TAGW = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            en_i,
    input  logic            tv_i,
    input  logic [TAGW-1:0] tag_i,
    output logic            tv_o,
    output logic [TAGW-1:0] tag_o
);

    logic [LAT-1:0]  r_tv;
    logic [TAGW-1:0] r_tag [LAT];

    // Shift owner tags in lock-step with the data pipeline
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tv <= '0;
            for (int k = 0; k < LAT; k++) r_tag[k] <= '0;
        end else if (flush_i) begin
            r_tv <= '0;
            for (int k = 0; k < LAT; k++) r_tag[k] <= '0;
        end else if (en_i) begin
            r_tv[0]  <= tv_i;
            r_tag[0] <= tag_i;
            for (int k = 1; k < LAT; k++) begin
                r_tv[k]  <= r_tv[k-1];
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    assign tv_o  = r_tv[LAT-1];
    assign tag_o = r_tag[LAT-1];

endmodule

// File: rtl/lix_pipe_arb.sv
// Round-robin arbiter and stall controller sharing one LAT-stage pipeline
// between NREQ requesters. Each in-flight item carries its owner in a
// mirrored tag pipe; the whole pipeline stalls while the owner of the output
// item is not ready.
// Optional macro LIX_PIPE_ARB_PERF_EN adds stall and per-requester grant
// counters (saturating, cleared by flush_i).
//
// Handshake: a request moves when req_vld_i[r] and req_rdy_o[r] are both 1;
// a response moves when rsp_vld_o[r] and rsp_rdy_i[r] are both 1. req_rdy_o
// and rsp_vld_o are each one-hot or zero, and are forced to zero in flush.
module lix_pipe_arb
    import lix_pipe_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int LAT  = 2,
    parameter int W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic [NREQ-1:0]   req_vld_i,
    input  logic [NREQ*W-1:0] req_dat_i,
    output logic [NREQ-1:0]   req_rdy_o,
    output logic              pipe_vld_o,
    output logic              pipe_en_o,
    output logic [W-1:0]      pipe_x_o,
    input  logic              pipe_vld_i,
    input  logic [W-1:0]      pipe_z_i,
    output logic [NREQ-1:0]   rsp_vld_o,
    output logic [W-1:0]      rsp_dat_o,
`ifdef LIX_PIPE_ARB_PERF_EN
    output logic [PERF_W-1:0]      stall_cnt_o,
    output logic [NREQ*PERF_W-1:0] gnt_cnt_o,
`endif
    input  logic [NREQ-1:0]   rsp_rdy_i
);

    localparam int TAGW = tag_width(NREQ);

    logic [TAGW-1:0]   r_ptr;
    logic [RR_MAX-1:0] w_req_ext;
    logic [RR_MAX-1:0] w_pick;
    logic              w_pick_hi;
    logic [NREQ-1:0]   w_gnt;
    logic              w_gnt_any;
    logic [TAGW-1:0]   w_gnt_idx;
    logic [W-1:0]      w_x;
    logic              w_tv_out;
    logic [TAGW-1:0]   w_tag_out;
    logic              w_out_busy;
    logic              w_own_rdy;
    logic              w_en;
    logic [NREQ-1:0]   w_rsp_vld;

    // Widen the request vector for the shared pick helper
    always_comb begin
        w_req_ext = '0;
        w_req_ext[NREQ-1:0] = req_vld_i;
    end

    assign w_pick    = rr_pick(w_req_ext, 32'(r_ptr), NREQ);
    // A pick outside the requester range is never a grant
    assign w_pick_hi = |w_pick[RR_MAX-1:NREQ];

    // Output item owner and its readiness; a tag beyond NREQ never matches
    assign w_out_busy = w_tv_out & pipe_vld_i;
    always_comb begin
        w_own_rdy = 1'b0;
        for (int r = 0; r < NREQ; r++)
            if (w_tag_out == TAGW'(r)) w_own_rdy = rsp_rdy_i[r];
    end

    // Advance unless the owned output item is blocked; flush always advances
    assign w_en = ~rst_i & (flush_i | ~(w_out_busy & ~w_own_rdy));

    // Grant only while advancing and not flushing
    assign w_gnt     = (w_en && !flush_i && !w_pick_hi) ? w_pick[NREQ-1:0] : '0;
    assign w_gnt_any = |w_gnt;

    // Encode the one-hot grant and select the granted data
    always_comb begin
        w_gnt_idx = '0;
        w_x       = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (w_gnt[r]) begin
                w_gnt_idx = TAGW'(r);
                w_x       = req_dat_i[r*W +: W];
            end
        end
    end

    // Route the output item to its owner; flush suppresses it
    always_comb begin
        w_rsp_vld = '0;
        for (int r = 0; r < NREQ; r++)
            if (w_out_busy && !flush_i && !rst_i && w_tag_out == TAGW'(r))
                w_rsp_vld[r] = 1'b1;
    end

    // Rotate the search start to just past the last granted requester
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (w_gnt_any) begin
            r_ptr <= (w_gnt_idx == TAGW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    lix_tag_pipe #(
        .LAT  (LAT),
        .TAGW (TAGW)
    ) u_tag_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .en_i    (w_en),
        .tv_i    (w_gnt_any),
        .tag_i   (w_gnt_idx),
        .tv_o    (w_tv_out),
        .tag_o   (w_tag_out)
    );

    assign req_rdy_o  = w_gnt;
    assign pipe_vld_o = w_gnt_any;
    assign pipe_en_o  = w_en;
    assign pipe_x_o   = w_x;
    assign rsp_vld_o  = w_rsp_vld;
    assign rsp_dat_o  = (|w_rsp_vld) ? pipe_z_i : '0;

`ifdef LIX_PIPE_ARB_PERF_EN
    logic [PERF_W-1:0] r_stall_cnt;
    logic [PERF_W-1:0] r_gnt_cnt [NREQ];

    // Count stalled cycles, saturating
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (flush_i) begin
            r_stall_cnt <= '0;
        end else if (!w_en && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // Count grants per requester, saturating
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREQ; r++) r_gnt_cnt[r] <= '0;
        end else if (flush_i) begin
            for (int r = 0; r < NREQ; r++) r_gnt_cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NREQ; r++)
                if (w_gnt[r] && r_gnt_cnt[r] != '1) r_gnt_cnt[r] <= r_gnt_cnt[r] + 1'b1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    for (genvar r = 0; r < NREQ; r++) begin : g_gnt_out
        assign gnt_cnt_o[r*PERF_W +: PERF_W] = r_gnt_cnt[r];
    end
`endif

endmodule
